univ_mod_counter: RTL and testbench
===================================

# univ_mod_counter

Parametrised up/down modulo counter: the general-purpose successor to the free-running binary counter. It adds a runtime modulus, synchronous clear, parallel load, count enable with prescaler, direction control, and wrap or saturate end behaviour. It sits beside timers, baud generators and display multiplexers, and drives both their counts and their terminal-count strobes.

## Interface
- N, 8: counter width in bits (N >= 2).
- SAT, 0: end-of-range behaviour; 0 = wrap, 1 = saturate.
- PRE, 1: prescale ratio; one count step per PRE enabled cycles (1 <= PRE <= 2**16).

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- syn_clr  in  1  synchronous clear of count and prescaler.
- load  in  1  parallel load of d.
- en  in  1  count enable; advances the prescaler.
- up  in  1  direction; 1 = increment, 0 = decrement.
- d  in  N  load value.
- mod_m  in  N  upper limit; counting range is 0..mod_m inclusive.
- q  out  N  registered count.
- max_tick  out  1  combinational; 1 when q >= mod_m.
- min_tick  out  1  combinational; 1 when q == 0.
- evt_tick  out  1  registered one-cycle pulse on a wrap or saturation event.

## Operation
- Priority per edge: reset > syn_clr > load > en; only the highest active input takes effect.
- reset or syn_clr: q <= 0, prescaler <= 0, evt_tick <= 0.
- load: q <= d if d <= mod_m, else q <= mod_m.
  - Prescaler <= 0; evt_tick <= 0.
  - en in the same cycle is ignored.
- en with load low:
  - If prescaler == PRE-1: prescaler <= 0 and a step is taken.
  - Otherwise: prescaler += 1; q holds; evt_tick <= 0.
- Step, up = 1:
  - q < mod_m: q <= q+1.
  - q >= mod_m, SAT = 0: q <= 0, evt_tick <= 1.
  - q >= mod_m, SAT = 1: q <= mod_m, evt_tick <= 1.
- Step, up = 0:
  - q > mod_m: q <= mod_m, evt_tick <= 0. This clamps after mod_m has been lowered.
  - 0 < q <= mod_m: q <= q-1.
  - q == 0, SAT = 0: q <= mod_m, evt_tick <= 1.
  - q == 0, SAT = 1: q holds 0, evt_tick <= 1.
- A step that is not an event clears evt_tick. en low holds q and the prescaler, and clears evt_tick.
- mod_m == 0: q stays 0 and every step is an event. A SAT=0 up step gives 0 -> 0 with evt_tick high.
- mod_m is sampled every cycle and is not latched. Changing it mid-count takes effect on the next step.
- Arithmetic is N-bit unsigned. No intermediate value exceeds N bits, because q+1 is only formed when q < mod_m.
- Prescaler width is max(1, clog2(PRE)). With PRE = 1 the prescaler is constant 0 and every enabled cycle is a step.
- up may change on any cycle; the new direction applies from the next step.

## Timing
- Reset values: q = 0, evt_tick = 0, prescaler = 0. After reset, max_tick = (mod_m == 0) and min_tick = 1.
- Latency: a step, load or clear is visible on q one cycle after the qualifying edge.
- evt_tick is high for exactly the cycle in which q shows the wrapped or saturated value. It repeats on every event, e.g. a held saturation with PRE = 1 keeps it high continuously.
- max_tick and min_tick follow q and mod_m combinationally, with no added latency.
- Reset asserted mid-count overrides all inputs on that edge. Counting resumes from 0 on the first enabled cycle after release, with the prescaler restarted.
- No reset-to-output combinational path: q and evt_tick are flops only.

## Test plan
- N=4, SAT=0, PRE=1, mod_m=9, up=1, en=1 for 12 cycles from reset -> q 1..9, 0, 1, 2. evt_tick high only in the cycle q=0 is shown. max_tick high while q=9.
- Same config, up=0 from q=0 -> q=9 with evt_tick high, then 8, 7. min_tick high only while q=0.
- SAT=1, mod_m=5, up=1, 8 steps -> q stops at 5 and evt_tick stays high every cycle after reaching 5. Then up=0 with 7 steps -> q reaches 0 and evt_tick is high each cycle at 0.
- PRE=3, en=1 continuous, mod_m=15 -> q advances once every 3 cycles. Pulsing syn_clr mid-interval -> q=0 and a full 3-cycle interval before the next step.
- Simultaneous load=1, en=1, syn_clr=0, d=12, mod_m=10 -> q=10 (clamped) and no step that cycle. Same cycle with syn_clr=1 -> q=0.
- Count up to q=200 (N=8, mod_m=255), then set mod_m=100:
  - Next up step -> q=0 with evt_tick (SAT=0).
  - Repeat with up=0 -> q=100 with evt_tick low.
  - Assert reset mid-run -> q=0, evt_tick=0 on the next cycle.

Source files
------------

// File: rtl/univ_mod_counter.sv
// univ_mod_counter: up/down modulo counter with runtime modulus, prescaler,
// synchronous clear, parallel load and wrap/saturate end behaviour.
//
// Parameters:
//   N   - counter width in bits (N >= 2)
//   SAT - 0 = wrap at the ends of the range, 1 = saturate
//   PRE - prescale ratio; one count step per PRE enabled cycles
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   reset_i      synchronous active-high reset
//   syn_clr_i    synchronous clear of count and prescaler
//   load_i       parallel load of d_i (clamped to mod_m_i)
//   en_i         count enable, advances the prescaler
//   up_i         direction, 1 = increment, 0 = decrement
//   d_i          load value
//   mod_m_i      upper limit, counting range is 0..mod_m_i
//   q_o          registered count
//   max_tick_o   q_o >= mod_m_i (combinational)
//   min_tick_o   q_o == 0 (combinational)
//   evt_tick_o   registered one-cycle pulse on a wrap or saturation event
module univ_mod_counter #(
  parameter int unsigned N   = 8,
  parameter int unsigned SAT = 0,
  parameter int unsigned PRE = 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         syn_clr_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic         up_i,
  input  logic [N-1:0] d_i,
  input  logic [N-1:0] mod_m_i,
  output logic [N-1:0] q_o,
  output logic         max_tick_o,
  output logic         min_tick_o,
  output logic         evt_tick_o
);

  localparam int unsigned PW = (PRE > 1) ? $clog2(PRE) : 1;
  localparam logic [PW-1:0] PreLast = PW'(PRE - 1);

  logic [N-1:0]  q_q, q_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          evt_q, evt_d;

  always_comb begin
    q_d   = q_q;
    pre_d = pre_q;
    evt_d = 1'b0;
    if (syn_clr_i) begin
      q_d   = '0;
      pre_d = '0;
    end else if (load_i) begin
      q_d   = (d_i <= mod_m_i) ? d_i : mod_m_i;
      pre_d = '0;
    end else if (en_i) begin
      if (pre_q == PreLast) begin
        pre_d = '0;
        if (up_i) begin
          // q+1 is only formed below mod_m, so it never overflows N bits
          if (q_q < mod_m_i) begin
            q_d = q_q + 1'b1;
          end else begin
            q_d   = (SAT != 0) ? mod_m_i : '0;
            evt_d = 1'b1;
          end
        end else begin
          if (q_q > mod_m_i) begin
            // Modulus was lowered below the count: clamp quietly
            q_d = mod_m_i;
          end else if (q_q != '0) begin
            q_d = q_q - 1'b1;
          end else begin
            q_d   = (SAT != 0) ? '0 : mod_m_i;
            evt_d = 1'b1;
          end
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q   <= '0;
      pre_q <= '0;
      evt_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      pre_q <= pre_d;
      evt_q <= evt_d;
    end
  end

  assign q_o        = q_q;
  assign evt_tick_o = evt_q;
  assign max_tick_o = (q_q >= mod_m_i);
  assign min_tick_o = (q_q == '0);

endmodule

// File: tb/tb_univ_mod_counter.sv
// Bench for univ_mod_counter: four instances share one stimulus stream
// (wrap, saturate, prescaled, narrow). A spec-level integer model predicts each
// instance; a checker compares every cycle, and directed phases pin literals.
module tb_univ_mod_counter;

  logic       clk;
  logic       reset, syn_clr, load, en, up;
  logic [7:0] d, mod_m;

  logic [7:0] q_a, q_b, q_c;
  logic [3:0] q_d;
  logic [3:0] max_t, min_t, evt_t;

  int n_cmp  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  // Model state per instance: 0 wrap/PRE1, 1 sat/PRE1, 2 wrap/PRE3, 3 N=4 wrap/PRE1
  int m_q[4];
  int m_p[4];
  int m_e[4];
  int cfg_sat[4]  = '{0, 1, 0, 0};
  int cfg_pre[4]  = '{1, 1, 3, 1};
  int cfg_mask[4] = '{255, 255, 255, 15};

  univ_mod_counter #(.N(8), .SAT(0), .PRE(1)) u_a (
    .clk_i(clk), .reset_i(reset), .syn_clr_i(syn_clr), .load_i(load), .en_i(en), .up_i(up),
    .d_i(d), .mod_m_i(mod_m), .q_o(q_a), .max_tick_o(max_t[0]), .min_tick_o(min_t[0]),
    .evt_tick_o(evt_t[0])
  );
  univ_mod_counter #(.N(8), .SAT(1), .PRE(1)) u_b (
    .clk_i(clk), .reset_i(reset), .syn_clr_i(syn_clr), .load_i(load), .en_i(en), .up_i(up),
    .d_i(d), .mod_m_i(mod_m), .q_o(q_b), .max_tick_o(max_t[1]), .min_tick_o(min_t[1]),
    .evt_tick_o(evt_t[1])
  );
  univ_mod_counter #(.N(8), .SAT(0), .PRE(3)) u_c (
    .clk_i(clk), .reset_i(reset), .syn_clr_i(syn_clr), .load_i(load), .en_i(en), .up_i(up),
    .d_i(d), .mod_m_i(mod_m), .q_o(q_c), .max_tick_o(max_t[2]), .min_tick_o(min_t[2]),
    .evt_tick_o(evt_t[2])
  );
  univ_mod_counter #(.N(4), .SAT(0), .PRE(1)) u_d (
    .clk_i(clk), .reset_i(reset), .syn_clr_i(syn_clr), .load_i(load), .en_i(en), .up_i(up),
    .d_i(d[3:0]), .mod_m_i(mod_m[3:0]), .q_o(q_d), .max_tick_o(max_t[3]),
    .min_tick_o(min_t[3]), .evt_tick_o(evt_t[3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_q(input int k);
    case (k)
      0: return int'(q_a);
      1: return int'(q_b);
      2: return int'(q_c);
      default: return int'(q_d);
    endcase
  endfunction

  // Reference model: follows the written rules with plain integers.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      int md, dd;
      md = int'(mod_m) & cfg_mask[k];
      dd = int'(d) & cfg_mask[k];
      if (reset || syn_clr) begin
        m_q[k] = 0; m_p[k] = 0; m_e[k] = 0;
      end else if (load) begin
        m_q[k] = (dd <= md) ? dd : md; m_p[k] = 0; m_e[k] = 0;
      end else if (en) begin
        if (m_p[k] == cfg_pre[k] - 1) begin
          m_p[k] = 0;
          m_e[k] = 0;
          if (up) begin
            if (m_q[k] < md) m_q[k] = m_q[k] + 1;
            else begin m_q[k] = cfg_sat[k] ? md : 0; m_e[k] = 1; end
          end else begin
            if (m_q[k] > md) m_q[k] = md;
            else if (m_q[k] > 0) m_q[k] = m_q[k] - 1;
            else begin m_q[k] = cfg_sat[k] ? 0 : md; m_e[k] = 1; end
          end
        end else begin
          m_p[k] = m_p[k] + 1; m_e[k] = 0;
        end
      end else begin
        m_e[k] = 0;
      end
    end
    if (reset) started = 1'b1;
    #1;
    if (started) begin
      for (int k = 0; k < 4; k++) begin
        int md;
        md = int'(mod_m) & cfg_mask[k];
        chk($sformatf("q[%0d]", k), dut_q(k), m_q[k]);
        chk($sformatf("evt[%0d]", k), int'(evt_t[k]), m_e[k]);
        chk($sformatf("max[%0d]", k), int'(max_t[k]), (m_q[k] >= md) ? 1 : 0);
        chk($sformatf("min[%0d]", k), int'(min_t[k]), (m_q[k] == 0) ? 1 : 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    reset = 1'b1; syn_clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1;
    d = 8'd0; mod_m = 8'd9;
    step();
    chk("rst_q", int'(q_a), 0);
    chk("rst_evt", int'(evt_t[0]), 0);
    chk("rst_min", int'(min_t[0]), 1);
    chk("rst_max", int'(max_t[0]), 0);
    reset = 1'b0; en = 1'b1;

    // Wrap up through mod_m = 9
    for (int i = 0; i < 12; i++) begin
      step();
      chk("up_q", int'(q_a), exp_up[i]);
      chk("up_q_n4", int'(q_d), exp_up[i]);
      chk("up_evt", int'(evt_t[0]), (i == 9) ? 1 : 0);
      chk("up_max", int'(max_t[0]), (exp_up[i] == 9) ? 1 : 0);
    end

    // Down wrap from 0
    syn_clr = 1'b1; step(); syn_clr = 1'b0; up = 1'b0;
    step(); chk("dn_q0", int'(q_a), 9); chk("dn_evt0", int'(evt_t[0]), 1);
    chk("dn_min0", int'(min_t[0]), 0);
    step(); chk("dn_q1", int'(q_a), 8); chk("dn_evt1", int'(evt_t[0]), 0);
    step(); chk("dn_q2", int'(q_a), 7);

    // Saturation at mod_m = 5 then at 0
    syn_clr = 1'b1; step(); syn_clr = 1'b0; mod_m = 8'd5; up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("sat_up_q", int'(q_b), (i + 1 < 5) ? i + 1 : 5);
      chk("sat_up_evt", int'(evt_t[1]), (i >= 5) ? 1 : 0);
    end
    up = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("sat_dn_q", int'(q_b), (4 - i > 0) ? 4 - i : 0);
      chk("sat_dn_evt", int'(evt_t[1]), (i >= 5) ? 1 : 0);
    end

    // Prescaler: one step per three enabled cycles, clear restarts the interval
    syn_clr = 1'b1; step(); syn_clr = 1'b0; mod_m = 8'd15; up = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("pre_q", int'(q_c), (i + 1) / 3);
    end
    syn_clr = 1'b1; step(); syn_clr = 1'b0;
    chk("pre_clr", int'(q_c), 0);
    step(); chk("pre_r0", int'(q_c), 0);
    step(); chk("pre_r1", int'(q_c), 0);
    step(); chk("pre_r2", int'(q_c), 1);

    // Load clamps and beats en; clear beats load
    load = 1'b1; d = 8'd12; mod_m = 8'd10;
    step(); chk("ld_clamp", int'(q_a), 10); chk("ld_clamp_n4", int'(q_d), 10);
    syn_clr = 1'b1;
    step(); chk("ld_clr", int'(q_a), 0);
    syn_clr = 1'b0; load = 1'b0;

    // Lowered modulus: up wraps with event, down clamps without event
    syn_clr = 1'b1; step(); syn_clr = 1'b0; mod_m = 8'd255; up = 1'b1;
    repeat (200) step();
    chk("cnt200", int'(q_a), 200);
    mod_m = 8'd100;
    step(); chk("low_up_q", int'(q_a), 0); chk("low_up_evt", int'(evt_t[0]), 1);
    chk("low_up_sat", int'(q_b), 100);
    syn_clr = 1'b1; step(); syn_clr = 1'b0; mod_m = 8'd255;
    repeat (200) step();
    mod_m = 8'd100; up = 1'b0;
    step(); chk("low_dn_q", int'(q_a), 100); chk("low_dn_evt", int'(evt_t[0]), 0);
    reset = 1'b1;
    step(); chk("mid_rst_q", int'(q_a), 0); chk("mid_rst_evt", int'(evt_t[0]), 0);
    reset = 1'b0;

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      syn_clr = ($urandom_range(0, 59) == 0);
      load    = ($urandom_range(0, 24) == 0);
      en      = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) up = ~up;
      d = 8'($urandom);
      if ($urandom_range(0, 29) == 0)
        mod_m = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
